dcache_flush_ctrl: RTL



---
 rtl/dcache_flush_ctrl_pkg.sv | 15 +
 rtl/dcache_flush_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dcache_flush_ctrl_pkg.sv
// dcache_flush_ctrl_pkg: shared cache typedefs, including the flush/kill walk states
package dcache_flush_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FL_TAG,
        FL_CHK,
        FL_DATA,
        FL_WB,
        FL_CLR,
        KILL,
        DONE
    } type_dcache_flush_states_e;

endpackage

// File: rtl/dcache_flush_ctrl.sv
// dcache_flush_ctrl: walks every set of the direct-mapped dcache, writing back dirty lines (flush) or invalidating all lines (kill)
// Ports: flush_req_i/kill_req_i start a walk; flush_ack_o pulses once when it ends; busy_o is high outside IDLE.
//   tag_rd_en_o/data_rd_en_o/tag_wr_* drive the synchronous tag and data arrays at index tag_addr_o;
//   tag_valid_i/tag_dirty_i/tag_i/data_line_i return read data one cycle after the enable.
//   mem_req_o/mem_w_en_o/mem_addr_o/mem_wdata_o issue a line writeback held until mem_ack_i.
// Build option: DCACHE_FLUSH_PERF_CNT_EN adds wb_count_o, the number of lines written back by the last flush.
module dcache_flush_ctrl
    import dcache_flush_ctrl_pkg::*;
#(
    parameter int NUM_SETS = 128,
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 128,
    localparam int IDX_W    = $clog2(NUM_SETS),
    localparam int OFFSET_W = $clog2(LINE_W / 8),
    localparam int TAG_W    = ADDR_W - IDX_W - OFFSET_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_req_i,
    input  logic              kill_req_i,
    output logic              flush_ack_o,
    output logic              busy_o,
    output logic              tag_rd_en_o,
    output logic [IDX_W-1:0]  tag_addr_o,
    input  logic              tag_valid_i,
    input  logic              tag_dirty_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              tag_wr_en_o,
    output logic              tag_wr_valid_o,
    output logic              tag_wr_dirty_o,
    output logic              data_rd_en_o,
    input  logic [LINE_W-1:0] data_line_i,
    output logic              mem_req_o,
    output logic              mem_w_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i
`ifdef DCACHE_FLUSH_PERF_CNT_EN
    ,
    output logic [IDX_W:0]    wb_count_o
`endif
);

    type_dcache_flush_states_e state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              kill_pend_q, kill_pend_d;
    logic [TAG_W-1:0]  hold_tag_q;
    logic [LINE_W-1:0] hold_line_q;
    logic              last_set, fl_walk, kill_now, wb_line;

    assign last_set = idx_q == IDX_W'(NUM_SETS - 1);
    assign fl_walk  = state_q inside {FL_TAG, FL_CHK, FL_DATA, FL_WB, FL_CLR};
    // A kill arriving in the very cycle of a check is honoured at once rather than lost.
    assign kill_now    = kill_pend_q | kill_req_i;
    assign kill_pend_d = fl_walk & kill_now;
    assign wb_line     = state_q == FL_CHK && tag_valid_i && tag_dirty_i;

    assign flush_ack_o    = state_q == DONE;
    assign busy_o         = state_q != IDLE;
    assign tag_rd_en_o    = state_q == FL_TAG;
    assign tag_addr_o     = idx_q;
    assign tag_wr_en_o    = state_q inside {FL_CLR, KILL};
    assign tag_wr_valid_o = state_q == FL_CLR;
    assign tag_wr_dirty_o = 1'b0;
    assign data_rd_en_o   = wb_line;
    assign mem_req_o      = state_q == FL_WB;
    assign mem_w_en_o     = state_q == FL_WB;
    assign mem_addr_o     = mem_req_o ? {hold_tag_q, idx_q, OFFSET_W'(0)} : '0;
    assign mem_wdata_o    = mem_req_o ? hold_line_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            kill_pend_q <= 1'b0;
            hold_tag_q  <= '0;
            hold_line_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            kill_pend_q <= kill_pend_d;
            if (state_q == FL_DATA) begin
                hold_tag_q  <= tag_i;
                hold_line_q <= data_line_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (kill_req_i || flush_req_i) begin
                state_d = kill_req_i ? KILL : FL_TAG;
                idx_d   = '0;
            end
            FL_TAG:  state_d = FL_CHK;
            FL_CHK, FL_CLR: begin
                if (wb_line) state_d = FL_DATA;
                else if (kill_now) begin
                    state_d = KILL;
                    idx_d   = '0;
                end else if (last_set) state_d = DONE;
                else begin
                    state_d = FL_TAG;
                    idx_d   = idx_q + 1'b1;
                end
            end
            FL_DATA: state_d = FL_WB;
            FL_WB:   state_d = mem_ack_i ? FL_CLR : FL_WB;
            KILL: begin
                state_d = last_set ? DONE : KILL;
                idx_d   = last_set ? idx_q : idx_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef DCACHE_FLUSH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wb_count_o <= '0;
        else if (state_q == IDLE && flush_req_i && !kill_req_i) wb_count_o <= '0;
        else if (state_q == FL_WB && mem_ack_i) wb_count_o <= wb_count_o + 1'b1;
    end
`endif

endmodule
